operand_stream_buffer: RTL and testbench

- Next-generation operand store for the matrix-multiply accelerator.
- Holds a square operand matrix of up to MAX_DIM x MAX_DIM elements, written row-wise over the bus with per-element strobes.
- Streams the matrix to the compute array under a valid/ready handshake, row-major or transposed (column-major).
- Streaming dimension is selectable at run time.
- Sits between the bus register file and the systolic/MAC array; one instance per operand (A, B).

---
 rtl/operand_stream_buffer.sv | 156 +++++++++++++++
 tb/tb_operand_stream_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stream_buffer.sv
// Square operand matrix store: row-wise bus writes with per-element strobes,
// streamed row-major or column-major over valid/ready. Optional OPBUF_CLEAR_EN adds clear_i.

// One output lane: element j of the current beat, masked to zero beyond n.
module operand_stream_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIM    = 4,
  parameter int LANE       = 0,
  localparam int BUS_WIDTH = DATA_WIDTH * MAX_DIM,
  localparam int AW        = $clog2(MAX_DIM)
) (
  input  logic [BUS_WIDTH-1:0]  row_k_i,
  input  logic [BUS_WIDTH-1:0]  row_j_i,
  input  logic [AW-1:0]         k_i,
  input  logic [AW-1:0]         dim_i,
  input  logic                  transpose_i,
  output logic [DATA_WIDTH-1:0] elem_o
);
  localparam logic [AW-1:0] LIDX = AW'(LANE);

  logic [MAX_DIM-1:0][DATA_WIDTH-1:0] row_k, row_j;
  assign row_k = row_k_i;
  assign row_j = row_j_i;

  always_comb begin
    elem_o = '0;
    if (LIDX <= dim_i)
      elem_o = transpose_i ? row_j[k_i] : row_k[LIDX];
  end
endmodule

module operand_stream_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 64,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int AW        = $clog2(MAX_DIM)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef OPBUF_CLEAR_EN
  input  logic                 clear_i,
`endif
  input  logic                 write_enable_i,
  input  logic [AW-1:0]        address_i,
  input  logic [MAX_DIM-1:0]   strobe_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  output logic [BUS_WIDTH-1:0] rd_data_o,
  input  logic [AW-1:0]        dim_i,
  input  logic                 transpose_i,
  input  logic                 start_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 write_err_o
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e                                           state_q, state_d;
  logic [AW-1:0]                                    k_q, k_d;
  logic [AW-1:0]                                    dim_q, dim_d;
  logic                                             tr_q, tr_d;
  logic                                             werr_q, werr_d;
  logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0]  mem_q, mem_d;
  logic [MAX_DIM-1:0][DATA_WIDTH-1:0]               wdata, beat;
  logic                                             busy, clr;

  assign busy  = (state_q != IDLE);
  assign wdata = data_i;

`ifdef OPBUF_CLEAR_EN
  assign clr = clear_i;
`else
  assign clr = 1'b0;
`endif

  // Storage next state: clear beats a same-cycle write; nothing changes while busy.
  always_comb begin
    mem_d = mem_q;
    if (!busy) begin
      if (clr) begin
        mem_d = '0;
      end else if (write_enable_i) begin
        for (int b = 0; b < MAX_DIM; b++)
          if (strobe_i[b]) mem_d[address_i][b] = wdata[b];
      end
    end
  end

  assign werr_d = busy & (write_enable_i | clr);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dim_d   = dim_q;
    tr_d    = tr_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        dim_d   = dim_i;
        tr_d    = transpose_i;
        k_d     = '0;
        state_d = SEND;
      end
      SEND: if (ready_i) begin
        k_d = k_q + 1'b1;
        if (k_q == dim_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      dim_q   <= '0;
      tr_q    <= 1'b0;
      werr_q  <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dim_q   <= dim_d;
      tr_q    <= tr_d;
      werr_q  <= werr_d;
      mem_q   <= mem_d;
    end
  end

  // Beat assembly: lane j sees row k (row-major) and row j (its column source).
  for (genvar j = 0; j < MAX_DIM; j++) begin : g_lane
    operand_stream_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_DIM   (MAX_DIM),
      .LANE      (j)
    ) u_lane (
      .row_k_i    (mem_q[k_q]),
      .row_j_i    (mem_q[j]),
      .k_i        (k_q),
      .dim_i      (dim_q),
      .transpose_i(tr_q),
      .elem_o     (beat[j])
    );
  end

  assign valid_o     = (state_q == SEND);
  assign last_o      = valid_o && (k_q == dim_q);
  assign data_o      = valid_o ? beat : '0;
  assign busy_o      = busy;
  assign done_o      = (state_q == DONE);
  assign write_err_o = werr_q;
  assign rd_data_o   = (!write_enable_i && !busy) ? mem_q[address_i] : '0;
endmodule

// File: tb/tb_operand_stream_buffer.sv
// Scoreboard bench for operand_stream_buffer: expected beats queued at start, popped on acceptance.
module tb_operand_stream_buffer;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        write_enable_i;
  logic [1:0]  address_i;
  logic [3:0]  strobe_i;
  logic [63:0] data_i;
  logic [63:0] rd_data_o;
  logic [1:0]  dim_i;
  logic        transpose_i;
  logic        start_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] data_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
  logic        write_err_o;

  always #5 clk_i = ~clk_i;

  operand_stream_buffer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
`ifdef OPBUF_CLEAR_EN
    .clear_i       (1'b0),
`endif
    .write_enable_i(write_enable_i),
    .address_i     (address_i),
    .strobe_i      (strobe_i),
    .data_i        (data_i),
    .rd_data_o     (rd_data_o),
    .dim_i         (dim_i),
    .transpose_i   (transpose_i),
    .start_i       (start_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
    .last_o        (last_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .write_err_o   (write_err_o)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] m [4][4];
  logic [64:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] row_of(input int r);
    logic [63:0] v;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = m[r][c];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = 16'h0;
  endtask

  task automatic model_write(input int a, input logic [3:0] s, input logic [63:0] d);
    for (int c = 0; c < 4; c++) if (s[c]) m[a][c] = d[c*16 +: 16];
  endtask

  task automatic wr(input int a, input logic [3:0] s, input logic [63:0] d);
    write_enable_i = 1'b1;
    address_i      = 2'(a);
    strobe_i       = s;
    data_i         = d;
    if (!busy_o) model_write(a, s, d);
    tick();
    write_enable_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a);
    address_i = 2'(a);
    #1;
    chk(tag, rd_data_o, row_of(a));
  endtask

  task automatic push_beats(input int dim, input bit tr);
    logic [63:0] v;
    for (int k = 0; k <= dim; k++) begin
      v = '0;
      for (int j = 0; j <= dim; j++) v[j*16 +: 16] = tr ? m[j][k] : m[k][j];
      sb.push_back({(k == dim), v});
    end
  endtask

  task automatic start_stream(input int dim, input bit tr);
    dim_i       = 2'(dim);
    transpose_i = tr;
    start_i     = 1'b1;
    push_beats(dim, tr);
    tick();
    start_i     = 1'b0;
    dim_i       = 2'($urandom_range(0, 3));
    transpose_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int stall_at, input int stall_n);
    int beat = 0, st = 0, cyc = 0, nb;
    nb = sb.size();
    while (sb.size() > 0 && cyc < 64) begin
      cyc++;
      chk("valid", 64'(valid_o), 64'd1);
      chk("data", data_o, sb[0][63:0]);
      chk("last", 64'(last_o), 64'(sb[0][64]));
      if (beat == stall_at && st < stall_n) begin
        ready_i = 1'b0;
        st++;
      end else begin
        ready_i = 1'b1;
        void'(sb.pop_front());
        beat++;
      end
      tick();
    end
    ready_i = 1'b0;
    chk("drain_left", 64'(sb.size()), 64'd0);
    chk("beats", 64'(beat), 64'(nb));
    chk("done", 64'(done_o), 64'd1);
    chk("done_valid", 64'(valid_o), 64'd0);
    chk("done_busy", 64'(busy_o), 64'd1);
    tick();
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_done", 64'(done_o), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; write_enable_i = 1'b0; address_i = '0; strobe_i = '0;
    data_i = '0; dim_i = '0; transpose_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
    clear_model();
    tick();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_werr", 64'(write_err_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    rst_ni = 1'b1;
    tick();
    rd_chk("rst_row0", 0);

    // load rows with r*4+c
    for (int r = 0; r < 4; r++)
      wr(r, 4'hF, {16'(r*4+3), 16'(r*4+2), 16'(r*4+1), 16'(r*4)});
    chk("idle_werr", 64'(write_err_o), 64'd0);
    for (int r = 0; r < 4; r++) rd_chk("load_row", r);

    start_stream(3, 0);
    chk("row0_const", data_o, 64'h0003_0002_0001_0000);
    drain(-1, 0);

    start_stream(3, 1);
    chk("col0_const", data_o, 64'h000C_0008_0004_0000);
    drain(-1, 0);

    start_stream(1, 0);
    chk("n2_const", data_o, 64'h0000_0000_0001_0000);
    drain(-1, 0);

    start_stream(3, 0);
    drain(1, 3);

    // partial strobe over zeros
    wr(2, 4'hF, 64'h0);
    wr(2, 4'b0101, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA});
    address_i = 2'd2;
    #1;
    chk("strb_row2", rd_data_o, 64'h0000_CCCC_0000_AAAA);
    rd_chk("strb_model", 2);

    // write rejected while streaming
    start_stream(3, 0);
    address_i = 2'd2;
    #1;
    chk("rd_busy", rd_data_o, 64'd0);
    wr(2, 4'hF, 64'h1111_2222_3333_4444);
    chk("werr_pulse", 64'(write_err_o), 64'd1);
    tick();
    chk("werr_clear", 64'(write_err_o), 64'd0);
    drain(-1, 0);
    rd_chk("row2_kept", 2);
    chk("row2_kept_const", rd_data_o, 64'h0000_CCCC_0000_AAAA);

    // simultaneous write and start: first beat sees new data
    write_enable_i = 1'b1; address_i = 2'd0; strobe_i = 4'hF;
    data_i = 64'h5555_6666_7777_8888;
    model_write(0, 4'hF, data_i);
    dim_i = 2'd3; transpose_i = 1'b0; start_i = 1'b1;
    push_beats(3, 0);
    tick();
    write_enable_i = 1'b0; start_i = 1'b0;
    chk("wr_start_const", data_o, 64'h5555_6666_7777_8888);
    drain(-1, 0);

    // reset during beat 2
    start_stream(3, 1);
    ready_i = 1'b1;
    chk("pre_rst_data", data_o, sb[0][63:0]);
    void'(sb.pop_front());
    tick();
    rst_ni = 1'b0;
    address_i = 2'd0;
    #1;
    chk("mrst_valid", 64'(valid_o), 64'd0);
    chk("mrst_busy", 64'(busy_o), 64'd0);
    chk("mrst_done", 64'(done_o), 64'd0);
    chk("mrst_data", data_o, 64'd0);
    chk("mrst_row0", rd_data_o, 64'd0);
    sb.delete();
    clear_model();
    ready_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_done", 64'(done_o), 64'd0);
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    rd_chk("post_rst_row3", 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
